// File: rtl/vgachargen_pkg.sv
// vgachargen_pkg
//   Shared types and constants for the vgachargen memory interface.
//   - Memory port widths for the character map, colour map and glyph table.
//   - APB address field positions used by the address decoder.
//   - Region and FSM state enumerations.
//   - Byte-lane merge helper for read-modify-write updates.
package vgachargen_pkg;

   localparam int CH_MAP_ADDR_WIDTH  = 12;
   localparam int CH_MAP_DATA_WIDTH  = 8;
   localparam int COL_MAP_ADDR_WIDTH = 12;
   localparam int COL_MAP_DATA_WIDTH = 8;
   localparam int CH_T_ADDR_WIDTH    = 7;
   localparam int CH_T_DATA_WIDTH    = 128;

   // 80 columns x 30 rows of text
   localparam int CH_MAP_ENTRIES_DEF = 2400;

   // PADDR field positions
   localparam int REGION_MSB    = 15;
   localparam int REGION_LSB    = 14;
   localparam int MAP_IDX_MSB   = 13;
   localparam int MAP_IDX_LSB   = 2;
   localparam int GLYPH_PAD_MSB = 13;
   localparam int GLYPH_PAD_LSB = 11;
   localparam int GLYPH_MSB     = 10;
   localparam int GLYPH_LSB     = 4;
   localparam int WORD_MSB      = 3;
   localparam int WORD_LSB      = 2;

   typedef enum logic [1:0] {
      REG_CH_MAP  = 2'b00,
      REG_COL_MAP = 2'b01,
      REG_CH_T_RW = 2'b10,
      REG_RSVD    = 2'b11
   } region_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_LATCH = 3'd2,
      ST_WRITE = 3'd3,
      ST_RESP  = 3'd4
   } apb_mem_state_e;

   // Replace the strobed byte lanes of old_word with those of new_word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/vgachargen_addr_decode.sv
// vgachargen_addr_decode
//   Combinational decode of the low 16 bits of an APB byte address into a
//   memory region, map index, glyph index, glyph word and an error flag.
// Ports:
//   paddr  in  16  byte address
//   region out 2   selected memory region
//   index  out 12  character/colour map entry index
//   glyph  out 7   glyph table entry
//   word   out 2   32-bit word inside a 128-bit glyph
//   err    out 1   reserved region, map index out of range, or glyph padding set
module vgachargen_addr_decode
   import vgachargen_pkg::*;
#(
   parameter int CH_MAP_ENTRIES = CH_MAP_ENTRIES_DEF
) (
   input  logic [15:0]                  paddr,
   output region_e                      region,
   output logic [CH_MAP_ADDR_WIDTH-1:0] index,
   output logic [CH_T_ADDR_WIDTH-1:0]   glyph,
   output logic [1:0]                   word,
   output logic                         err
);

   // Byte offset inside a 32-bit word carries no information.
   logic unused_lsb;
   assign unused_lsb = ^paddr[1:0];

   always_comb begin
      region = region_e'(paddr[REGION_MSB:REGION_LSB]);
      index  = paddr[MAP_IDX_MSB:MAP_IDX_LSB];
      glyph  = paddr[GLYPH_MSB:GLYPH_LSB];
      word   = paddr[WORD_MSB:WORD_LSB];
      err    = 1'b0;
      case (region)
         REG_CH_MAP,
         REG_COL_MAP: err = (32'(index) >= 32'(CH_MAP_ENTRIES));
         REG_CH_T_RW: err = (paddr[GLYPH_PAD_MSB:GLYPH_PAD_LSB] != 3'd0);
         default:     err = 1'b1;
      endcase
   end

endmodule

// File: rtl/vgachargen_apb_mem_if.sv
// vgachargen_apb_mem_if
//   APB4 completer for the bus-side port A of the character map, colour map
//   and glyph table. Every write is a read-modify-write so byte strobes merge
//   into the narrow map entries or the 128-bit glyph rows.
// Ports:
//   clk_i, arstn_i           clock, asynchronous active-low reset
//   psel_i .. pstrb_i        APB request
//   pready_o, prdata_o,
//   pslverr_o                APB response
//   ch_map_*                 character map port A (1-cycle read latency)
//   col_map_*                colour map port A (1-cycle read latency)
//   ch_t_rw_*                glyph table port A (1-cycle read latency)
module vgachargen_apb_mem_if
   import vgachargen_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 16,
   parameter int CH_MAP_ENTRIES = CH_MAP_ENTRIES_DEF
) (
   input  logic                          clk_i,
   input  logic                          arstn_i,
   input  logic                          psel_i,
   input  logic                          penable_i,
   input  logic                          pwrite_i,
   input  logic [APB_ADDR_WIDTH-1:0]     paddr_i,
   input  logic [31:0]                   pwdata_i,
   input  logic [3:0]                    pstrb_i,
   output logic                          pready_o,
   output logic [31:0]                   prdata_o,
   output logic                          pslverr_o,
   output logic [CH_MAP_ADDR_WIDTH-1:0]  ch_map_addr_o,
   output logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_o,
   output logic                          ch_map_wen_o,
   input  logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_i,
   output logic [COL_MAP_ADDR_WIDTH-1:0] col_map_addr_o,
   output logic [COL_MAP_DATA_WIDTH-1:0] col_map_data_o,
   output logic                          col_map_wen_o,
   input  logic [COL_MAP_DATA_WIDTH-1:0] col_map_data_i,
   output logic [CH_T_ADDR_WIDTH-1:0]    ch_t_rw_addr_o,
   output logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_o,
   output logic                          ch_t_rw_wen_o,
   input  logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_i
);

   apb_mem_state_e state, state_next;

   // Latched transfer
   logic                       wr_ff;
   logic                       err_ff;
   region_e                    region_ff;
   logic [1:0]                 word_ff;
   logic [31:0]                wdata_ff;
   logic [3:0]                 strb_ff;
   logic [CH_T_DATA_WIDTH-1:0] rdata_ff;

   // Decode of the live bus address, used in IDLE
   region_e                      dec_region;
   logic [CH_MAP_ADDR_WIDTH-1:0] dec_index;
   logic [CH_T_ADDR_WIDTH-1:0]   dec_glyph;
   logic [1:0]                   dec_word;
   logic                         dec_err;

   // Bits above the 64 KiB window are ignored.
   logic unused_paddr;
   assign unused_paddr = ^paddr_i;

   vgachargen_addr_decode #(
      .CH_MAP_ENTRIES (CH_MAP_ENTRIES)
   ) u_addr_decode (
      .paddr  (paddr_i[15:0]),
      .region (dec_region),
      .index  (dec_index),
      .glyph  (dec_glyph),
      .word   (dec_word),
      .err    (dec_err)
   );

   wire start = (state == ST_IDLE) && psel_i;

   // State register
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Next state; once started the transfer runs to completion regardless of psel_i.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (psel_i) state_next = ST_REQ;
         ST_REQ:   state_next = err_ff ? ST_RESP : ST_LATCH;
         ST_LATCH: state_next = wr_ff ? ST_WRITE : ST_RESP;
         ST_WRITE: state_next = ST_RESP;
         ST_RESP:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // APB response, derived from state so reset clears it immediately.
   always_comb begin
      pready_o  = (state == ST_RESP);
      pslverr_o = (state == ST_RESP) && err_ff;
      prdata_o  = 32'd0;
      if ((state == ST_RESP) && !err_ff && !wr_ff) begin
         if (region_ff == REG_CH_T_RW) prdata_o = rdata_ff[{word_ff, 5'b0} +: 32];
         else                          prdata_o = {24'd0, rdata_ff[CH_MAP_DATA_WIDTH-1:0]};
      end
   end

   // Transfer control captured at the start of a transfer
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         wr_ff     <= 1'b0;
         err_ff    <= 1'b0;
         region_ff <= REG_CH_MAP;
      end else if (start) begin
         wr_ff     <= pwrite_i;
         err_ff    <= dec_err;
         region_ff <= dec_region;
      end
   end

   // Transfer payload and captured read data
   always_ff @(posedge clk_i) begin
      if (start) begin
         word_ff  <= dec_word;
         wdata_ff <= pwdata_i;
         strb_ff  <= pstrb_i;
      end
      if (state == ST_LATCH) begin
         case (region_ff)
            REG_CH_MAP:  rdata_ff <= CH_T_DATA_WIDTH'(ch_map_data_i);
            REG_COL_MAP: rdata_ff <= CH_T_DATA_WIDTH'(col_map_data_i);
            default:     rdata_ff <= ch_t_rw_data_i;
         endcase
      end
   end

   // Merged write data, built from the read data arriving in LATCH
   logic [CH_MAP_DATA_WIDTH-1:0]  ch_merged;
   logic [COL_MAP_DATA_WIDTH-1:0] col_merged;
   logic [CH_T_DATA_WIDTH-1:0]    glyph_merged;

   always_comb begin
      ch_merged    = strb_ff[0] ? wdata_ff[CH_MAP_DATA_WIDTH-1:0] : ch_map_data_i;
      col_merged   = strb_ff[0] ? wdata_ff[COL_MAP_DATA_WIDTH-1:0] : col_map_data_i;
      glyph_merged = ch_t_rw_data_i;
      glyph_merged[{word_ff, 5'b0} +: 32] =
         merge_bytes(ch_t_rw_data_i[{word_ff, 5'b0} +: 32], wdata_ff, strb_ff);
   end

   // Memory port A drive. The address is registered on the setup edge so the
   // 1-cycle read data is available in LATCH. Write enables are registered so
   // the asynchronous reset removes an in-flight write at once.
   wire do_write = (state == ST_LATCH) && wr_ff;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         ch_map_addr_o  <= '0;
         ch_map_data_o  <= '0;
         ch_map_wen_o   <= 1'b0;
         col_map_addr_o <= '0;
         col_map_data_o <= '0;
         col_map_wen_o  <= 1'b0;
         ch_t_rw_addr_o <= '0;
         ch_t_rw_data_o <= '0;
         ch_t_rw_wen_o  <= 1'b0;
      end else begin
         ch_map_wen_o  <= 1'b0;
         col_map_wen_o <= 1'b0;
         ch_t_rw_wen_o <= 1'b0;
         if (start && !dec_err) begin
            case (dec_region)
               REG_CH_MAP:  ch_map_addr_o  <= dec_index;
               REG_COL_MAP: col_map_addr_o <= dec_index;
               REG_CH_T_RW: ch_t_rw_addr_o <= dec_glyph;
               default: ;
            endcase
         end
         if (do_write) begin
            case (region_ff)
               REG_CH_MAP: begin
                  ch_map_data_o <= ch_merged;
                  ch_map_wen_o  <= 1'b1;
               end
               REG_COL_MAP: begin
                  col_map_data_o <= col_merged;
                  col_map_wen_o  <= 1'b1;
               end
               REG_CH_T_RW: begin
                  ch_t_rw_data_o <= glyph_merged;
                  ch_t_rw_wen_o  <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
